// File: rtl/control_fsm.sv
// Hardwired multi-cycle control unit for the 16-bit bus datapath: fetch over a ready
// handshake, decode IR, sequence per-state strobes, latch ALU flags for branches.
module control_fsm #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir,
   input  logic        zin,
   input  logic        sin,
   input  logic        vin,
   input  logic        cin,
   input  logic        mem_ready,
   output logic        lmar,
   output logic        lt,
   output logic        lpc,
   output logic        lir,
   output logic        lmdr,
   output logic        ldx,
   output logic        ldy,
   output logic        tt,
   output logic        tpc,
   output logic        tp,
   output logic        t2,
   output logic        tmdr2x,
   output logic        tmdrext,
   output logic        rmdri,
   output logic        rmarx,
   output logic [2:0]  pa,
   output logic        rdr,
   output logic [2:0]  wpa,
   output logic        wrr,
   output logic [2:0]  fnsel,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        halt,
   output logic        err
);

   localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

   localparam logic [4:0] ST_IDLE = 5'd0;
   localparam logic [4:0] ST_F0   = 5'd1;
   localparam logic [4:0] ST_F1   = 5'd2;
   localparam logic [4:0] ST_F2   = 5'd3;
   localparam logic [4:0] ST_F3   = 5'd4;
   localparam logic [4:0] ST_DEC  = 5'd5;
   localparam logic [4:0] ST_E0   = 5'd6;
   localparam logic [4:0] ST_E1   = 5'd7;
   localparam logic [4:0] ST_E2   = 5'd8;
   localparam logic [4:0] ST_L0   = 5'd9;
   localparam logic [4:0] ST_L1   = 5'd10;
   localparam logic [4:0] ST_L2   = 5'd11;
   localparam logic [4:0] ST_L3   = 5'd12;
   localparam logic [4:0] ST_L4   = 5'd13;
   localparam logic [4:0] ST_S0   = 5'd14;
   localparam logic [4:0] ST_S1   = 5'd15;
   localparam logic [4:0] ST_S2   = 5'd16;
   localparam logic [4:0] ST_S3   = 5'd17;
   localparam logic [4:0] ST_S4   = 5'd18;
   localparam logic [4:0] ST_B0   = 5'd19;
   localparam logic [4:0] ST_B1   = 5'd20;
   localparam logic [4:0] ST_B2   = 5'd21;
   localparam logic [4:0] ST_HLT  = 5'd22;
   localparam logic [4:0] ST_ERR  = 5'd23;

   localparam logic [2:0] FN_ADD  = 3'b000;
   localparam logic [2:0] FN_PASS = 3'b100;

   logic [4:0]    state_q, state_d;
   logic [3:0]    flags_q, flags_d;   // {Z,S,V,C}
   logic [CW-1:0] cnt_q, cnt_d;

   logic [3:0] op;
   logic [2:0] rd, rs1, rs2;
   logic       in_wait;
   logic       timeout;

   assign op  = ir[15:12];
   assign rd  = ir[11:9];
   assign rs1 = ir[8:6];
   assign rs2 = ir[5:3];

   // S/V/C are latched for future conditional branches; only Z is consumed today.
   logic unused_bits;
   assign unused_bits = ^{ir[2:0], flags_q[2:0]};

   assign in_wait = (state_q == ST_F3) || (state_q == ST_L2) || (state_q == ST_S4);
   // A ready in the limit cycle still completes the transfer.
   assign timeout = in_wait && !mem_ready && (cnt_q == CW'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         flags_q <= 4'b0000;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      flags_d = flags_q;
      cnt_d   = (in_wait && !mem_ready && !timeout) ? cnt_q + CW'(1) : '0;
      case (state_q)
         ST_IDLE: state_d = ST_F0;
         ST_F0:   state_d = ST_F1;
         ST_F1:   state_d = ST_F2;
         ST_F2:   state_d = ST_F3;
         ST_F3: begin
            if (mem_ready)    state_d = ST_DEC;
            else if (timeout) state_d = ST_ERR;
         end
         ST_DEC: begin
            case (op)
               4'b0000, 4'b0001, 4'b0010, 4'b0011: state_d = ST_E0;
               4'b0100: state_d = ST_L0;
               4'b0101: state_d = ST_S0;
               4'b0110: state_d = flags_q[3] ? ST_B0 : ST_F0;
               4'b0111: state_d = ST_HLT;
               default: state_d = ST_F0;
            endcase
         end
         ST_E0:   state_d = ST_E1;
         ST_E1:   state_d = ST_E2;
         ST_E2: begin
            flags_d = {zin, sin, vin, cin};
            state_d = ST_F0;
         end
         ST_L0:   state_d = ST_L1;
         ST_L1:   state_d = ST_L2;
         ST_L2: begin
            if (mem_ready)    state_d = ST_L3;
            else if (timeout) state_d = ST_ERR;
         end
         ST_L3:   state_d = ST_L4;
         ST_L4:   state_d = ST_F0;
         ST_S0:   state_d = ST_S1;
         ST_S1:   state_d = ST_S2;
         ST_S2:   state_d = ST_S3;
         ST_S3:   state_d = ST_S4;
         ST_S4: begin
            if (mem_ready)    state_d = ST_F0;
            else if (timeout) state_d = ST_ERR;
         end
         ST_B0:   state_d = ST_B1;
         ST_B1:   state_d = ST_B2;
         ST_B2:   state_d = ST_F0;
         ST_HLT:  state_d = ST_HLT;
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes decode from state only, except the load strobes that close a memory read.
   always_comb begin
      lmar    = 1'b0;
      lt      = 1'b0;
      lpc     = 1'b0;
      lir     = 1'b0;
      lmdr    = 1'b0;
      ldx     = 1'b0;
      ldy     = 1'b0;
      tt      = 1'b0;
      tpc     = 1'b0;
      tp      = 1'b0;
      t2      = 1'b0;
      tmdr2x  = 1'b0;
      tmdrext = 1'b0;
      rmdri   = 1'b0;
      rmarx   = 1'b0;
      pa      = 3'b000;
      rdr     = 1'b0;
      wpa     = 3'b000;
      wrr     = 1'b0;
      fnsel   = FN_ADD;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      halt    = 1'b0;
      err     = 1'b0;
      case (state_q)
         ST_F0: begin
            tpc = 1'b1; ldx = 1'b1; fnsel = FN_PASS;
         end
         ST_F1: begin
            fnsel = FN_PASS; lmar = 1'b1; t2 = 1'b1; ldy = 1'b1;
         end
         ST_F2: begin
            fnsel = FN_ADD; lpc = 1'b1; mem_rd = 1'b1;
         end
         ST_F3: begin
            mem_rd = 1'b1; rmarx = 1'b1;
            lmdr = mem_ready; lir = mem_ready;
         end
         ST_E0: begin
            pa = rs1; rdr = 1'b1; tp = 1'b1; ldx = 1'b1;
         end
         ST_E1: begin
            pa = rs2; rdr = 1'b1; tp = 1'b1; ldy = 1'b1;
         end
         ST_E2: begin
            fnsel = op[2:0]; wrr = 1'b1; wpa = rd;
         end
         ST_L0, ST_S0: begin
            pa = rs1; rdr = 1'b1; tp = 1'b1; ldx = 1'b1;
         end
         ST_L1, ST_S1: begin
            fnsel = FN_PASS; lmar = 1'b1;
         end
         ST_L2: begin
            mem_rd = 1'b1; rmarx = 1'b1; lmdr = mem_ready;
         end
         ST_L3: begin
            tmdr2x = 1'b1; ldx = 1'b1;
         end
         ST_L4: begin
            fnsel = FN_PASS; wrr = 1'b1; wpa = rd;
         end
         ST_S2: begin
            pa = rd; rdr = 1'b1; tp = 1'b1; ldx = 1'b1;
         end
         ST_S3: begin
            fnsel = FN_PASS; rmdri = 1'b1; lmdr = 1'b1;
         end
         ST_S4: begin
            mem_wr = 1'b1;
         end
         ST_B0: begin
            tpc = 1'b1; ldx = 1'b1;
         end
         ST_B1: begin
            pa = rs1; rdr = 1'b1; tp = 1'b1; ldy = 1'b1;
         end
         ST_B2: begin
            fnsel = FN_ADD; lpc = 1'b1;
         end
         ST_HLT: begin
            halt = 1'b1;
         end
         ST_ERR: begin
            halt = 1'b1; err = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
